// File: rtl/div_unit_if.sv
// Request and register write-back bundle for div_unit.
// slave: divider side; master: issuing/observing side.
interface div_unit_if;
    logic        start;
    logic        signed_op;
    logic        rem_sel;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [2:0]  dest_reg;
    logic        busy;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic [31:0] write_data;
    logic        div_by_zero;

    modport slave (
        input  start,
        input  signed_op,
        input  rem_sel,
        input  dividend,
        input  divisor,
        input  dest_reg,
        output busy,
        output reg_write,
        output write_reg,
        output write_data,
        output div_by_zero
    );

    modport master (
        output start,
        output signed_op,
        output rem_sel,
        output dividend,
        output divisor,
        output dest_reg,
        input  busy,
        input  reg_write,
        input  write_reg,
        input  write_data,
        input  div_by_zero
    );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider, one quotient bit per cycle.
// Ports: clk, reset (sync, active-high), bus (div_unit_if.slave).
module div_unit (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic        q_neg;
    logic        r_neg;
    logic        rsel;
    logic        dz;
    logic [2:0]  dreg;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] result;

    always_comb begin
        a_mag = bus.dividend;
        b_mag = bus.divisor;
        if (bus.signed_op && bus.dividend[31])
            a_mag = ~bus.dividend + 32'd1;
        if (bus.signed_op && bus.divisor[31])
            b_mag = ~bus.divisor + 32'd1;
        // Partial remainder stays below the divisor, so the shifted
        // trial fits in 33 bits and bit 32 of diff is a clean borrow.
        trial  = {rem, quo[31]};
        diff   = trial - {1'b0, dvs};
        ge     = ~diff[32];
        q_fix  = q_neg ? (~quo + 32'd1) : quo;
        r_fix  = r_neg ? (~rem + 32'd1) : rem;
        result = rsel ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 6'd0;
            quo   <= 32'd0;
            rem   <= 32'd0;
            dvs   <= 32'd0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            rsel  <= 1'b0;
            dz    <= 1'b0;
            dreg  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rsel <= bus.rem_sel;
                        dreg <= bus.dest_reg;
                        dvs  <= b_mag;
                        cnt  <= 6'd0;
                        if (bus.divisor == 32'd0) begin
                            // Fixed result, no sign fix-up applied.
                            quo   <= 32'hFFFF_FFFF;
                            rem   <= bus.dividend;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            dz    <= 1'b1;
                            state <= DONE;
                        end else begin
                            quo   <= a_mag;
                            rem   <= 32'd0;
                            q_neg <= bus.signed_op &
                                     (bus.dividend[31] ^ bus.divisor[31]);
                            r_neg <= bus.signed_op & bus.dividend[31];
                            dz    <= 1'b0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // quo doubles as the dividend shift register.
                    rem <= ge ? diff[31:0] : trial[31:0];
                    quo <= {quo[30:0], ge};
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31)
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    dz    <= 1'b0;
                    cnt   <= 6'd0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.reg_write   = (state == DONE) && (dreg != 3'd0);
    assign bus.write_reg   = (state == DONE) ? dreg : 3'd0;
    assign bus.write_data  = (state == DONE) ? result : 32'd0;
    assign bus.div_by_zero = (state == DONE) && dz;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Drives the master side of div_unit_if and checks write-back results.
module tb_div_unit;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;
    int   t0;
    int   ta;
    int   lat;
    int   nb;
    int   nw;

    div_unit_if bus ();

    div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h",
                   tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic s, input logic r,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] d);
        bus.signed_op = s;
        bus.rem_sel   = r;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.dest_reg  = d;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        t0 = cyc;
    endtask

    // Latency 1 = the cycle right after the sampling edge.
    task automatic wait_wr(output int l);
        while (!bus.reg_write && (cyc - t0) < 40)
            tick();
        l = bus.reg_write ? (cyc - t0 + 1) : -1;
    endtask

    task automatic check_result(input string tag, input int exp_lat,
                                input logic [2:0] exp_reg,
                                input logic [31:0] exp_data,
                                input logic exp_dz);
        wait_wr(lat);
        chk({tag, "/lat"}, lat, exp_lat);
        chk({tag, "/reg"}, {29'd0, bus.write_reg}, {29'd0, exp_reg});
        chk({tag, "/data"}, bus.write_data, exp_data);
        chk({tag, "/dz"}, {31'd0, bus.div_by_zero}, {31'd0, exp_dz});
        tick();
        chk({tag, "/wr_off"}, {31'd0, bus.reg_write}, 32'd0);
        chk({tag, "/idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        t0        = 0;
        reset     = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.rem_sel   = 1'b0;
        bus.dividend  = 32'd0;
        bus.divisor   = 32'd0;
        bus.dest_reg  = 3'd0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst/busy", {31'd0, bus.busy}, 32'd0);
        chk("rst/wr", {31'd0, bus.reg_write}, 32'd0);
        chk("rst/dz", {31'd0, bus.div_by_zero}, 32'd0);
        chk("rst/reg", {29'd0, bus.write_reg}, 32'd0);
        chk("rst/data", bus.write_data, 32'd0);

        start_op(1'b0, 1'b0, 32'd100, 32'd7, 3'd3);
        chk("u100_7/busy", {31'd0, bus.busy}, 32'd1);
        check_result("u100_7/q", 33, 3'd3, 32'd14, 1'b0);
        start_op(1'b0, 1'b1, 32'd100, 32'd7, 3'd3);
        check_result("u100_7/r", 33, 3'd3, 32'd2, 1'b0);

        start_op(1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7, 3'd1);
        check_result("sm100_7/q", 33, 3'd1, 32'hFFFF_FFF2, 1'b0);
        start_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 3'd1);
        check_result("sm100_7/r", 33, 3'd1, 32'hFFFF_FFFE, 1'b0);

        start_op(1'b1, 1'b1, 32'd100, 32'hFFFF_FFF9, 3'd2);
        check_result("s100_m7/r", 33, 3'd2, 32'd2, 1'b0);

        start_op(1'b0, 1'b0, 32'h1234_5678, 32'd0, 3'd5);
        check_result("dz/q", 1, 3'd5, 32'hFFFF_FFFF, 1'b1);
        start_op(1'b0, 1'b1, 32'h1234_5678, 32'd0, 3'd5);
        check_result("dz/r", 1, 3'd5, 32'h1234_5678, 1'b1);
        start_op(1'b1, 1'b0, 32'h8000_0005, 32'd0, 3'd4);
        check_result("sdz/q", 1, 3'd4, 32'hFFFF_FFFF, 1'b1);
        start_op(1'b1, 1'b1, 32'h8000_0005, 32'd0, 3'd4);
        check_result("sdz/r", 1, 3'd4, 32'h8000_0005, 1'b1);

        start_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 3'd6);
        check_result("ovf/q", 33, 3'd6, 32'h8000_0000, 1'b0);
        start_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 3'd6);
        check_result("ovf/r", 33, 3'd6, 32'd0, 1'b0);

        start_op(1'b0, 1'b0, 32'd200, 32'd10, 3'd2);
        while (cyc - t0 + 1 < 10)
            tick();
        bus.signed_op = 1'b1;
        bus.rem_sel   = 1'b1;
        bus.dividend  = 32'd9;
        bus.divisor   = 32'd0;
        bus.dest_reg  = 3'd4;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        check_result("ignore", 33, 3'd2, 32'd20, 1'b0);

        start_op(1'b0, 1'b0, 32'd1000, 32'd3, 3'd7);
        while (cyc - t0 + 1 < 20)
            tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst/busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst/wr", {31'd0, bus.reg_write}, 32'd0);
        nw = 0;
        for (int i = 0; i < 40; i++) begin
            nw += int'(bus.reg_write);
            tick();
        end
        chk("midrst/no_wr", nw, 32'd0);
        start_op(1'b0, 1'b0, 32'd81, 32'd9, 3'd7);
        check_result("after_rst", 33, 3'd7, 32'd9, 1'b0);

        start_op(1'b0, 1'b0, 32'd50, 32'd5, 3'd0);
        nb = 0;
        nw = 0;
        for (int i = 0; i < 40; i++) begin
            nb += int'(bus.busy);
            nw += int'(bus.reg_write);
            tick();
        end
        chk("dst0/busy_cycles", nb, 32'd33);
        chk("dst0/no_wr", nw, 32'd0);

        start_op(1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7, 3'd6);
        ta = t0;
        check_result("b2b/first", 33, 3'd6, 32'hFFFF_FFF2, 1'b0);
        start_op(1'b0, 1'b1, 32'd100, 32'd7, 3'd7);
        chk("b2b/period", t0 - ta, 32'd34);
        check_result("b2b/second", 33, 3'd7, 32'd2, 1'b0);

        bus.signed_op = 1'b0;
        bus.dividend  = 32'd1;
        bus.divisor   = 32'd0;
        bus.dest_reg  = 3'd1;
        bus.start     = 1'b1;
        reset         = 1'b1;
        tick();
        reset         = 1'b0;
        bus.start     = 1'b0;
        chk("rst_prio/busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_prio/dz", {31'd0, bus.div_by_zero}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
